// File: rtl/graphics_bus_writer_pkg.sv
// Shared constants for the graphics write port: register map, chipselect
// code, commit word and the bus writer state encoding.
package graphics_bus_writer_pkg;

    localparam int NUM_WORDS        = 10;
    localparam int WORD_W           = 16;
    localparam int HOLD_CYCLES      = 2;

    // Register map, shared with the graphics-side decode
    localparam logic [3:0] ADDR_P1X    = 4'd0;
    localparam logic [3:0] ADDR_P1Y    = 4'd1;
    localparam logic [3:0] ADDR_P2X    = 4'd2;
    localparam logic [3:0] ADDR_P2Y    = 4'd3;
    localparam logic [3:0] ADDR_BALLX  = 4'd4;
    localparam logic [3:0] ADDR_BALLY  = 4'd5;
    localparam logic [3:0] ADDR_BALLZ  = 4'd6;
    localparam logic [3:0] ADDR_P1S    = 4'd7;
    localparam logic [3:0] ADDR_P2S    = 4'd8;
    localparam logic [3:0] ADDR_GSTATE = 4'd9;
    localparam logic [3:0] COMMIT_ADDR = 4'hF;

    localparam logic [3:0]  CS_GFX      = 4'b0001;
    localparam logic [3:0]  CS_IDLE     = 4'b0000;
    localparam logic [15:0] COMMIT_DATA = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } gbw_state_t;

    // A word goes out when forced, when the graphics side holds nothing
    // trustworthy yet, or when it differs from what was last written.
    function automatic logic word_needs_send(
        input logic        force_flag,
        input logic        shadow_valid,
        input logic [15:0] snap_word,
        input logic [15:0] shadow_word
    );
        return force_flag | ~shadow_valid | (snap_word != shadow_word);
    endfunction

endpackage

// File: rtl/graphics_bus_writer_word_mux.sv
// Combinational 10:1 select of the snapshot and shadow words at one index.
module gbw_word_mux
    import graphics_bus_writer_pkg::*;
(
    input  logic [3:0]                  index,
    input  logic [NUM_WORDS*WORD_W-1:0] snap_flat,
    input  logic [NUM_WORDS*WORD_W-1:0] shadow_flat,
    output logic [WORD_W-1:0]           snap_word,
    output logic [WORD_W-1:0]           shadow_word
);

    // Pick the indexed word; out-of-range indices read as zero
    always_comb begin
        snap_word   = 16'h0000;
        shadow_word = 16'h0000;
        if (index < 4'(NUM_WORDS)) begin
            snap_word   = snap_flat[index*WORD_W +: WORD_W];
            shadow_word = shadow_flat[index*WORD_W +: WORD_W];
        end else begin
            snap_word   = 16'h0000;
            shadow_word = 16'h0000;
        end
    end

endmodule

// File: rtl/graphics_bus_writer.sv
// Bus master that pushes changed game-state words to the graphics block,
// followed by a commit word that makes the graphics side swap buffers.
module graphics_bus_writer #(
    parameter logic [3:0] CS_GFX      = graphics_bus_writer_pkg::CS_GFX,
    parameter int         HOLD_CYCLES = graphics_bus_writer_pkg::HOLD_CYCLES,
    parameter logic [3:0] COMMIT_ADDR = graphics_bus_writer_pkg::COMMIT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update_req,
    input  logic        force_all,
    input  logic        bus_grant,
    input  logic [15:0] paddle_1_x,
    input  logic [15:0] paddle_1_y,
    input  logic [15:0] paddle_2_x,
    input  logic [15:0] paddle_2_y,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    input  logic [15:0] ball_z,
    input  logic [15:0] p1_score,
    input  logic [15:0] p2_score,
    input  logic [15:0] game_state,
    output logic [3:0]  chipselect,
    output logic [15:0] databus,
    output logic [3:0]  data_address,
    output logic        busy,
    output logic        done,
    output logic [3:0]  words_sent
);
    import graphics_bus_writer_pkg::*;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);

    gbw_state_t                             state_r;
    logic [3:0]                             idx_r;
    logic [7:0]                             hold_r;
    logic                                   active_r;
    logic                                   force_r;
    logic                                   pending_r;
    logic                                   pending_force_r;
    logic                                   shadow_valid_r;
    logic [3:0]                             sent_cnt_r;
    logic [NUM_WORDS-1:0][WORD_W-1:0]       snap_r;
    logic [NUM_WORDS-1:0][WORD_W-1:0]       shadow_r;
    logic [NUM_WORDS-1:0][WORD_W-1:0]       inputs_s;
    logic [WORD_W-1:0]                      snap_word_s;
    logic [WORD_W-1:0]                      shadow_word_s;
    logic                                   need_send_s;

    // Gather the live inputs into register-map order for snapshotting
    always_comb begin
        inputs_s              = '0;
        inputs_s[ADDR_P1X]    = paddle_1_x;
        inputs_s[ADDR_P1Y]    = paddle_1_y;
        inputs_s[ADDR_P2X]    = paddle_2_x;
        inputs_s[ADDR_P2Y]    = paddle_2_y;
        inputs_s[ADDR_BALLX]  = ball_x;
        inputs_s[ADDR_BALLY]  = ball_y;
        inputs_s[ADDR_BALLZ]  = ball_z;
        inputs_s[ADDR_P1S]    = p1_score;
        inputs_s[ADDR_P2S]    = p2_score;
        inputs_s[ADDR_GSTATE] = game_state;
    end

    gbw_word_mux u_word_mux (
        .index       (idx_r),
        .snap_flat   (snap_r),
        .shadow_flat (shadow_r),
        .snap_word   (snap_word_s),
        .shadow_word (shadow_word_s)
    );

    // Decide whether the word at the current scan index has to go out
    always_comb begin
        need_send_s = 1'b0;
        need_send_s = word_needs_send(force_r, shadow_valid_r, snap_word_s, shadow_word_s);
    end

    // Transfer sequencer: scan, drive, gap, commit, done; all outputs registered.
    // Grant is sampled on the edge that would put a word on the bus, so a
    // stalled word leaves the bus idle until the edge that sees grant high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            idx_r           <= 4'd0;
            hold_r          <= 8'd0;
            active_r        <= 1'b0;
            force_r         <= 1'b0;
            pending_r       <= 1'b0;
            pending_force_r <= 1'b0;
            shadow_valid_r  <= 1'b0;
            sent_cnt_r      <= 4'd0;
            snap_r          <= '0;
            shadow_r        <= '0;
            chipselect      <= CS_IDLE;
            databus         <= 16'h0000;
            data_address    <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            words_sent      <= 4'd0;
        end else begin
            if (update_req && (state_r inside {ST_SCAN, ST_DRIVE, ST_GAP, ST_COMMIT})) begin
                pending_r       <= 1'b1;
                pending_force_r <= pending_force_r | force_all;
            end
            case (state_r)
                ST_IDLE: begin
                    if (update_req) begin
                        snap_r     <= inputs_s;
                        force_r    <= force_all;
                        idx_r      <= 4'd0;
                        sent_cnt_r <= 4'd0;
                        words_sent <= 4'd0;
                        busy       <= 1'b1;
                        state_r    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (need_send_s) begin
                        state_r  <= ST_DRIVE;
                        active_r <= bus_grant;
                        hold_r   <= HOLD_LOAD;
                        if (bus_grant) begin
                            chipselect   <= CS_GFX;
                            data_address <= idx_r;
                            databus      <= snap_word_s;
                        end
                    end else if (idx_r == LAST_IDX) begin
                        state_r  <= ST_COMMIT;
                        active_r <= bus_grant;
                        hold_r   <= HOLD_LOAD;
                        if (bus_grant) begin
                            chipselect   <= CS_GFX;
                            data_address <= COMMIT_ADDR;
                            databus      <= COMMIT_DATA;
                        end
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!active_r) begin
                        if (bus_grant) begin
                            active_r     <= 1'b1;
                            chipselect   <= CS_GFX;
                            data_address <= idx_r;
                            databus      <= snap_word_s;
                        end
                    end else if (hold_r == 8'd0) begin
                        active_r        <= 1'b0;
                        chipselect      <= CS_IDLE;
                        data_address    <= 4'd0;
                        databus         <= 16'h0000;
                        shadow_r[idx_r] <= snap_word_s;
                        sent_cnt_r      <= sent_cnt_r + 4'd1;
                        state_r         <= ST_GAP;
                    end else begin
                        hold_r <= hold_r - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (idx_r == LAST_IDX) begin
                        state_r  <= ST_COMMIT;
                        active_r <= bus_grant;
                        hold_r   <= HOLD_LOAD;
                        if (bus_grant) begin
                            chipselect   <= CS_GFX;
                            data_address <= COMMIT_ADDR;
                            databus      <= COMMIT_DATA;
                        end
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        state_r <= ST_SCAN;
                    end
                end
                ST_COMMIT: begin
                    if (!active_r) begin
                        if (bus_grant) begin
                            active_r     <= 1'b1;
                            chipselect   <= CS_GFX;
                            data_address <= COMMIT_ADDR;
                            databus      <= COMMIT_DATA;
                        end
                    end else if (hold_r == 8'd0) begin
                        active_r       <= 1'b0;
                        chipselect     <= CS_IDLE;
                        data_address   <= 4'd0;
                        databus        <= 16'h0000;
                        shadow_valid_r <= 1'b1;
                        done           <= 1'b1;
                        words_sent     <= sent_cnt_r;
                        state_r        <= ST_DONE;
                    end else begin
                        hold_r <= hold_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (pending_r || update_req) begin
                        snap_r          <= inputs_s;
                        force_r         <= pending_force_r | (update_req & force_all);
                        pending_r       <= 1'b0;
                        pending_force_r <= 1'b0;
                        idx_r           <= 4'd0;
                        sent_cnt_r      <= 4'd0;
                        words_sent      <= 4'd0;
                        state_r         <= ST_SCAN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    active_r     <= 1'b0;
                    chipselect   <= CS_IDLE;
                    data_address <= 4'd0;
                    databus      <= 16'h0000;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_graphics_bus_writer.sv
// Directed bench for graphics_bus_writer: a bus monitor collects every word
// seen on the bus and each scenario compares it with a hand-built list.
module tb_graphics_bus_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        update_req;
    logic        force_all;
    logic        bus_grant;
    logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
    logic [15:0] ball_x, ball_y, ball_z, p1_score, p2_score, game_state;
    logic [3:0]  chipselect;
    logic [15:0] databus;
    logic [3:0]  data_address;
    logic        busy;
    logic        done;
    logic [3:0]  words_sent;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int req_cyc = 0;

    logic [3:0]  mon_addr[$];
    logic [15:0] mon_data[$];
    int          mon_len[$];
    logic [3:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_len[$];
    int idle_bad = 0, stab_bad = 0, cs_bad = 0;
    logic        in_word = 1'b0;
    logic [3:0]  cur_addr;
    logic [15:0] cur_data;
    int          cur_len;

    graphics_bus_writer dut (
        .clk(clk), .rst(rst), .update_req(update_req), .force_all(force_all),
        .bus_grant(bus_grant),
        .paddle_1_x(paddle_1_x), .paddle_1_y(paddle_1_y),
        .paddle_2_x(paddle_2_x), .paddle_2_y(paddle_2_y),
        .ball_x(ball_x), .ball_y(ball_y), .ball_z(ball_z),
        .p1_score(p1_score), .p2_score(p2_score), .game_state(game_state),
        .chipselect(chipselect), .databus(databus), .data_address(data_address),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: one entry per word, with the number of cycles it was held
    always @(negedge clk) begin
        if (chipselect != 4'd0) begin
            if (!in_word) begin
                in_word  = 1'b1;
                cur_addr = data_address;
                cur_data = databus;
                cur_len  = 1;
                if (chipselect != 4'b0001) cs_bad++;
            end else begin
                cur_len++;
                if (data_address != cur_addr || databus != cur_data) stab_bad++;
            end
        end else begin
            if (databus != 16'h0000 || data_address != 4'd0) idle_bad++;
            if (in_word) begin
                mon_addr.push_back(cur_addr);
                mon_data.push_back(cur_data);
                mon_len.push_back(cur_len);
                in_word = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_exp(input logic [3:0] a, input logic [15:0] d, input int len);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_len.push_back(len);
    endtask

    task automatic check_words(input string tag, input int base);
        check_val({tag, "_count"}, 32'(mon_addr.size() - base), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (base + i < mon_addr.size()) begin
                check_val({tag, "_addr"}, 32'(mon_addr[base+i]), 32'(exp_addr[i]));
                check_val({tag, "_data"}, 32'(mon_data[base+i]), 32'(exp_data[i]));
                check_val({tag, "_hold"}, 32'(mon_len[base+i]), 32'(exp_len[i]));
            end
        end
        exp_addr.delete();
        exp_data.delete();
        exp_len.delete();
    endtask

    task automatic pulse_req(input logic f);
        req_cyc    = cyc;
        update_req = 1'b1;
        force_all  = f;
        @(negedge clk);
        update_req = 1'b0;
        force_all  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 400);
        if (done !== 1'b1) check_val("done_timeout", 32'(done), 32'd1);
        lat = cyc - req_cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_all(input logic [15:0] d [10]);
        for (int i = 0; i < 10; i++) add_exp(4'(i), d[i], 2);
        add_exp(4'hF, 16'h0001, 2);
    endtask

    initial begin
        int base;
        int lat;
        int rc;
        logic [15:0] vals [10];

        rst = 1'b0; update_req = 1'b0; force_all = 1'b0; bus_grant = 1'b1;
        paddle_1_x = 16'd1; paddle_1_y = 16'd2; paddle_2_x = 16'd3; paddle_2_y = 16'd4;
        ball_x = 16'd5; ball_y = 16'd6; ball_z = 16'd7;
        p1_score = 16'd8; p2_score = 16'd9; game_state = 16'd10;
        repeat (3) @(negedge clk);
        check_val("rst_cs",    32'(chipselect),   32'd0);
        check_val("rst_data",  32'(databus),      32'd0);
        check_val("rst_addr",  32'(data_address), 32'd0);
        check_val("rst_busy",  32'(busy),         32'd0);
        check_val("rst_done",  32'(done),         32'd0);
        check_val("rst_wsent", 32'(words_sent),   32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: first transfer sends all ten words
        base = mon_addr.size();
        pulse_req(1'b0);
        check_val("t1_busy_early", 32'(busy), 32'd1);
        wait_done(lat);
        check_val("t1_latency", 32'(lat), 32'd43);
        check_val("t1_wsent", 32'(words_sent), 32'd10);
        check_val("t1_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("t1_busy_after", 32'(busy), 32'd0);
        check_val("t1_done_pulse", 32'(done), 32'd0);
        check_val("t1_wsent_hold", 32'(words_sent), 32'd10);
        vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        expect_all(vals);
        check_words("t1", base);

        // 2: one changed word
        ball_x = 16'h0123;
        base = mon_addr.size();
        pulse_req(1'b0);
        wait_done(lat);
        check_val("t2_latency", 32'(lat), 32'd16);
        check_val("t2_wsent", 32'(words_sent), 32'd1);
        @(negedge clk);
        add_exp(4'd4, 16'h0123, 2);
        add_exp(4'hF, 16'h0001, 2);
        check_words("t2", base);

        // 3a: nothing changed, forced resend of everything
        base = mon_addr.size();
        pulse_req(1'b1);
        wait_done(lat);
        check_val("t3a_latency", 32'(lat), 32'd43);
        check_val("t3a_wsent", 32'(words_sent), 32'd10);
        @(negedge clk);
        vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'h0123, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        expect_all(vals);
        check_words("t3a", base);

        // 3b: nothing changed, commit only
        base = mon_addr.size();
        pulse_req(1'b0);
        wait_done(lat);
        check_val("t3b_latency", 32'(lat), 32'd13);
        check_val("t3b_wsent", 32'(words_sent), 32'd0);
        @(negedge clk);
        add_exp(4'hF, 16'h0001, 2);
        check_words("t3b", base);

        // 4: grant withheld for five cycles when word 2 is due
        paddle_2_x = 16'h2222;
        base = mon_addr.size();
        pulse_req(1'b0);
        rc = req_cyc;
        wait_until(rc + 3);
        bus_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_val("t4_stall_idle", 32'(chipselect), 32'd0);
            @(negedge clk);
        end
        check_val("t4_stall_idle_last", 32'(chipselect), 32'd0);
        bus_grant = 1'b1;
        @(negedge clk);
        check_val("t4_word_cs",   32'(chipselect),   32'd1);
        check_val("t4_word_addr", 32'(data_address), 32'd2);
        check_val("t4_word_data", 32'(databus),      32'h2222);
        wait_done(lat);
        check_val("t4_latency", 32'(lat), 32'd21);
        check_val("t4_wsent", 32'(words_sent), 32'd1);
        @(negedge clk);
        add_exp(4'd2, 16'h2222, 2);
        add_exp(4'hF, 16'h0001, 2);
        check_words("t4", base);
        base = mon_addr.size();
        pulse_req(1'b0);
        wait_done(lat);
        check_val("t4_shadow_wsent", 32'(words_sent), 32'd0);
        @(negedge clk);
        add_exp(4'hF, 16'h0001, 2);
        check_words("t4_shadow", base);

        // 5: two requests while busy merge into one extra transfer
        ball_y = 16'h0555;
        base = mon_addr.size();
        pulse_req(1'b0);
        rc = req_cyc;
        wait_until(rc + 3);
        pulse_req(1'b0);
        wait_until(rc + 5);
        ball_z = 16'h0666;
        wait_until(rc + 7);
        pulse_req(1'b0);
        wait_until(rc + 12);
        ball_z = 16'h0777;
        wait_done(lat);
        wait_done(lat);
        check_val("t5_wsent", 32'(words_sent), 32'd1);
        repeat (20) @(negedge clk);
        check_val("t5_idle_after", 32'(busy), 32'd0);
        add_exp(4'd5, 16'h0555, 2);
        add_exp(4'hF, 16'h0001, 2);
        add_exp(4'd6, 16'h0777, 2);
        add_exp(4'hF, 16'h0001, 2);
        check_words("t5", base);

        // 6: reset in the middle of word 5, then full resend
        base = mon_addr.size();
        pulse_req(1'b1);
        rc = req_cyc;
        wait_until(rc + 22);
        check_val("t6_w5_cs",   32'(chipselect),   32'd1);
        check_val("t6_w5_addr", 32'(data_address), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_rst_cs",   32'(chipselect),   32'd0);
        check_val("t6_rst_data", 32'(databus),      32'd0);
        check_val("t6_rst_addr", 32'(data_address), 32'd0);
        check_val("t6_rst_busy", 32'(busy),         32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t6_no_commit", 32'(mon_addr.size() - base), 32'd6);
        if (mon_addr.size() > 0) begin
            check_val("t6_last_addr", 32'(mon_addr[mon_addr.size()-1]), 32'd5);
            check_val("t6_last_hold", 32'(mon_len[mon_len.size()-1]), 32'd1);
        end
        base = mon_addr.size();
        pulse_req(1'b0);
        wait_done(lat);
        check_val("t6_latency", 32'(lat), 32'd43);
        check_val("t6_wsent", 32'(words_sent), 32'd10);
        @(negedge clk);
        vals = '{16'd1, 16'd2, 16'h2222, 16'd4, 16'h0123, 16'h0555, 16'h0777, 16'd8, 16'd9, 16'd10};
        expect_all(vals);
        check_words("t6", base);

        check_val("bus_idle_zero", 32'(idle_bad), 32'd0);
        check_val("bus_stable",    32'(stab_bad), 32'd0);
        check_val("bus_cs_code",   32'(cs_bad),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
